// File: rtl/sram_arb_pkg.sv
// Shared types for the two-master SRAM-bus request arbiter.
// Source IDs and the bundled request-field struct.
package sram_arb_pkg;

   localparam logic SRC_INST = 1'b0;
   localparam logic SRC_DATA = 1'b1;

   typedef logic src_id_t;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_fields_t;

endpackage

// File: rtl/id_fifo.sv
// Ordered source-ID queue: one entry per accepted, unanswered request.
// Power-of-2 depth, so the pointers wrap on their own.
module id_fifo
   import sram_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  src_id_t       din,
   output src_id_t       dout,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   localparam logic [AW-1:0] P_ONE = AW'(1);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   src_id_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign count   = cnt;
   assign dout    = mem[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + P_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + P_ONE;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + C_ONE;
            2'b01:   cnt <= cnt - C_ONE;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-master, one-slave SRAM-bus arbiter with grant lock on stall
// and in-order response routing through a source-ID queue.
module sram_req_arbiter
   import sram_arb_pkg::*;
#(
   parameter int MAX_OUTST = 4,
   localparam int CW = $clog2(MAX_OUTST) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inst_req,
   input  logic          inst_wr,
   input  logic [1:0]    inst_size,
   input  logic [3:0]    inst_wstrb,
   input  logic [31:0]   inst_addr,
   input  logic [31:0]   inst_wdata,
   output logic          inst_addr_ok,
   output logic          inst_data_ok,
   output logic [31:0]   inst_rdata,
   input  logic          data_req,
   input  logic          data_wr,
   input  logic [1:0]    data_size,
   input  logic [3:0]    data_wstrb,
   input  logic [31:0]   data_addr,
   input  logic [31:0]   data_wdata,
   output logic          data_addr_ok,
   output logic          data_data_ok,
   output logic [31:0]   data_rdata,
   output logic          mem_req,
   output logic          mem_wr,
   output logic [1:0]    mem_size,
   output logic [3:0]    mem_wstrb,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic          mem_addr_ok,
   input  logic          mem_data_ok,
   input  logic [31:0]   mem_rdata,
   output logic [CW-1:0] outst_cnt,
   output logic          err_spurious
);

   req_fields_t inst_f;
   req_fields_t data_f;
   req_fields_t mem_f;
   src_id_t     grant;
   src_id_t     lock_owner;
   src_id_t     head;
   logic        lock;
   logic        grant_req;
   logic        q_empty;
   logic        q_full;
   logic        accept;
   logic        pop;

   assign inst_f = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
   assign data_f = {data_wr, data_size, data_wstrb, data_addr, data_wdata};

   // A stalled owner keeps the grant; otherwise data wins.
   assign grant     = lock ? lock_owner : (data_req ? SRC_DATA : SRC_INST);
   assign grant_req = (grant == SRC_DATA) ? data_req : inst_req;
   assign mem_req   = grant_req & ~q_full;
   assign accept    = mem_req & mem_addr_ok;
   assign pop       = mem_data_ok & ~q_empty;

   assign mem_f = (mem_req && grant == SRC_INST) ? inst_f : data_f;
   assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = mem_f;

   assign inst_addr_ok = accept & (grant == SRC_INST);
   assign data_addr_ok = accept & (grant == SRC_DATA);
   assign inst_data_ok = pop & (head == SRC_INST);
   assign data_data_ok = pop & (head == SRC_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock       <= 1'b0;
         lock_owner <= SRC_INST;
      end else if (mem_req) begin
         lock       <= ~mem_addr_ok;
         lock_owner <= grant;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_spurious <= 1'b0;
      end else if (mem_data_ok && q_empty) begin
         err_spurious <= 1'b1;
      end
   end

   id_fifo #(
      .DEPTH (MAX_OUTST)
   ) u_ids (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .pop   (pop),
      .din   (grant),
      .dout  (head),
      .empty (q_empty),
      .full  (q_full),
      .count (outst_cnt)
   );

endmodule
